ysyx_22041211_ifu: RTL and testbench

//  Instruction fetch unit. Upstream producer of the decoder's inst/pc inputs.

---
 rtl/ysyx_22041211_ifu_if.sv | 33 +++
 rtl/ysyx_22041211_ifu.sv | 148 ++++++++++++++
 tb/tb_ysyx_22041211_ifu.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041211_ifu_if.sv
// Fetch-unit bus bundle: redirect input, imem req/ack port and decoder valid/ready port.
// fetch_fault_o exists only when YSYX_22041211_IFU_MISALIGN_EN is defined.
interface ysyx_22041211_ifu_if;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
`ifdef YSYX_22041211_IFU_MISALIGN_EN
  logic        fetch_fault_o;
`endif

  modport master (
    input  redirect_valid_i, redirect_pc_i, imem_ack_i, imem_rdata_i, inst_ready_i,
    output imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o
`ifdef YSYX_22041211_IFU_MISALIGN_EN
    , output fetch_fault_o
`endif
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i, imem_ack_i, imem_rdata_i, inst_ready_i,
    input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o
`ifdef YSYX_22041211_IFU_MISALIGN_EN
    , input fetch_fault_o
`endif
  );
endinterface

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: one imem transaction per word, registered hand-off to the decoder.
// YSYX_22041211_IFU_MISALIGN_EN enables misaligned-redirect faults and the HALT state.
module ysyx_22041211_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic                 clk,
  input logic                 rst,
  ysyx_22041211_ifu_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DROP  = 3'd2,
    S_OUT   = 3'd3
`ifdef YSYX_22041211_IFU_MISALIGN_EN
    , S_HALT = 3'd4
`endif
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_tgt, w_tgt_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_pc_out, w_pc_out_nxt;
  logic        r_valid, w_valid_nxt;
  logic        w_jump;
  logic [31:0] w_jump_pc;
  logic [31:0] w_redir_pc;
  logic        w_redir;

  assign w_redir = bus.redirect_valid_i;

`ifdef YSYX_22041211_IFU_MISALIGN_EN
  logic r_fault, w_fault_nxt;
  assign w_redir_pc        = bus.redirect_pc_i;
  assign bus.fetch_fault_o = r_fault;
`else
  assign w_redir_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
`endif

  assign bus.imem_req_o   = (r_state == S_FETCH) || (r_state == S_DROP);
  assign bus.imem_addr_o  = r_pc;
  assign bus.inst_valid_o = r_valid;
  assign bus.inst_o       = r_inst;
  assign bus.pc_o         = r_pc_out;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_tgt_nxt    = r_tgt;
    w_inst_nxt   = r_inst;
    w_pc_out_nxt = r_pc_out;
    w_valid_nxt  = r_valid;
    w_jump       = 1'b0;
    w_jump_pc    = w_redir_pc;
`ifdef YSYX_22041211_IFU_MISALIGN_EN
    w_fault_nxt  = r_fault;
`endif
    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack_i && !w_redir) begin
          w_inst_nxt   = bus.imem_rdata_i;
          w_pc_out_nxt = r_pc;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = S_OUT;
        end else if (bus.imem_ack_i) begin
          w_jump = 1'b1;
        end else if (w_redir) begin
          // The bus address must hold until ack, so park the target.
          w_tgt_nxt   = w_redir_pc;
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.imem_ack_i) begin
          w_jump = 1'b1;
          if (!w_redir) w_jump_pc = r_tgt;
        end else if (w_redir) begin
          w_tgt_nxt = w_redir_pc;
        end
      end
      S_OUT: begin
        if (w_redir) begin
          w_jump = 1'b1;
        end else if (bus.inst_ready_i) begin
          w_valid_nxt = 1'b0;
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = S_FETCH;
`ifdef YSYX_22041211_IFU_MISALIGN_EN
          if (r_fault) begin
            w_pc_nxt    = r_pc;
            w_fault_nxt = 1'b0;
            w_state_nxt = S_HALT;
          end
`endif
        end
      end
`ifdef YSYX_22041211_IFU_MISALIGN_EN
      S_HALT: if (w_redir) w_jump = 1'b1;
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_jump) begin
      w_pc_nxt    = w_jump_pc;
      w_valid_nxt = 1'b0;
      w_state_nxt = S_FETCH;
`ifdef YSYX_22041211_IFU_MISALIGN_EN
      w_fault_nxt = 1'b0;
      // Misaligned target: no bus request, report the fault as a pseudo-instruction.
      if (w_jump_pc[1:0] != 2'b00) begin
        w_valid_nxt  = 1'b1;
        w_fault_nxt  = 1'b1;
        w_inst_nxt   = 32'd0;
        w_pc_out_nxt = w_jump_pc;
        w_state_nxt  = S_OUT;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_tgt    <= RESET_PC;
      r_inst   <= 32'd0;
      r_pc_out <= 32'd0;
      r_valid  <= 1'b0;
`ifdef YSYX_22041211_IFU_MISALIGN_EN
      r_fault  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_tgt    <= w_tgt_nxt;
      r_inst   <= w_inst_nxt;
      r_pc_out <= w_pc_out_nxt;
      r_valid  <= w_valid_nxt;
`ifdef YSYX_22041211_IFU_MISALIGN_EN
      r_fault  <= w_fault_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Directed bench for ysyx_22041211_ifu: streaming, wait states, back-pressure, redirects, reset.
module tb_ysyx_22041211_ifu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        auto_mem, man_ack, redir_v, ready;
  logic [31:0] man_rdata, redir_pc;
  int          errors = 0;
  int          checks = 0;

  ysyx_22041211_ifu_if bus();

  // Zero-wait memory in auto mode returns the inverted address as the word.
  assign bus.imem_ack_i       = auto_mem ? bus.imem_req_o : man_ack;
  assign bus.imem_rdata_i     = auto_mem ? ~bus.imem_addr_o : man_rdata;
  assign bus.redirect_valid_i = redir_v;
  assign bus.redirect_pc_i    = redir_pc;
  assign bus.inst_ready_i     = ready;

  ysyx_22041211_ifu #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; auto_mem = 1'b0; man_ack = 1'b0; man_rdata = 32'd0;
    redir_v = 1'b0; redir_pc = 32'd0; ready = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b0, RST_PC}) begin
      errors++; $display("FAIL reset_bus: got req=%b addr=%h want req=0 addr=%h", bus.imem_req_o, bus.imem_addr_o, RST_PC);
    end
    checks++;
    if ({bus.inst_valid_o, bus.inst_o, bus.pc_o} !== {1'b0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL reset_out: got valid=%b inst=%h pc=%h want 0/0/0", bus.inst_valid_o, bus.inst_o, bus.pc_o);
    end
`ifdef YSYX_22041211_IFU_MISALIGN_EN
    checks++;
    if (bus.fetch_fault_o !== 1'b0) begin
      errors++; $display("FAIL reset_fault: got %b want 0", bus.fetch_fault_o);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_stream;
    logic [31:0] e;
    auto_mem = 1'b1; ready = 1'b1;
    tick();
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o} !== {1'b1, RST_PC, 1'b0}) begin
      errors++; $display("FAIL stream_first_req: got req=%b addr=%h valid=%b want 1/%h/0", bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o, RST_PC);
    end
    for (int k = 0; k < 3; k++) begin
      e = RST_PC + 32'(4 * k);
      tick();
      checks++;
      if ({bus.inst_valid_o, bus.pc_o, bus.inst_o} !== {1'b1, e, ~e}) begin
        errors++; $display("FAIL stream_word%0d: got valid=%b pc=%h inst=%h want 1/%h/%h", k, bus.inst_valid_o, bus.pc_o, bus.inst_o, e, ~e);
      end
`ifdef YSYX_22041211_IFU_MISALIGN_EN
      checks++;
      if (bus.fetch_fault_o !== 1'b0) begin
        errors++; $display("FAIL stream_fault%0d: got %b want 0", k, bus.fetch_fault_o);
      end
`endif
      tick();
      checks++;
      if ({bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o} !== {1'b0, 1'b1, e + 32'd4}) begin
        errors++; $display("FAIL stream_gap%0d: got valid=%b req=%b addr=%h want 0/1/%h", k, bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o, e + 32'd4);
      end
    end
    auto_mem = 1'b0; man_ack = 1'b0;
  endtask

  task automatic test_wait_ack;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o} !== {1'b1, 32'h8000_000C, 1'b0}) begin
        errors++; $display("FAIL wait_hold%0d: got req=%b addr=%h valid=%b want 1/8000000c/0", i, bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o);
      end
      if (i < 3) tick();
    end
    man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    tick();
    man_ack = 1'b0;
    checks++;
    if ({bus.inst_valid_o, bus.pc_o, bus.inst_o, bus.imem_req_o} !== {1'b1, 32'h8000_000C, 32'hDEAD_BEEF, 1'b0}) begin
      errors++; $display("FAIL wait_word: got valid=%b pc=%h inst=%h req=%b want 1/8000000c/deadbeef/0", bus.inst_valid_o, bus.pc_o, bus.inst_o, bus.imem_req_o);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.inst_valid_o, bus.pc_o, bus.inst_o, bus.imem_req_o} !== {1'b1, 32'h8000_000C, 32'hDEAD_BEEF, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d: got valid=%b pc=%h inst=%h req=%b want 1/8000000c/deadbeef/0", i, bus.inst_valid_o, bus.pc_o, bus.inst_o, bus.imem_req_o);
      end
    end
    ready = 1'b1;
    tick();
    checks++;
    if ({bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o} !== {1'b0, 1'b1, 32'h8000_0010}) begin
      errors++; $display("FAIL bp_next: got valid=%b req=%b addr=%h want 0/1/80000010", bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_drop;
    redir_v = 1'b1; redir_pc = 32'h8000_0080;
    tick();
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o} !== {1'b1, 32'h8000_0010, 1'b0}) begin
      errors++; $display("FAIL drop_hold0: got req=%b addr=%h valid=%b want 1/80000010/0", bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o);
    end
    redir_pc = 32'h8000_0100;
    tick();
    redir_v = 1'b0;
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o} !== {1'b1, 32'h8000_0010, 1'b0}) begin
      errors++; $display("FAIL drop_hold1: got req=%b addr=%h valid=%b want 1/80000010/0", bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o);
    end
    man_ack = 1'b1; man_rdata = 32'h1111_1111;
    tick();
    man_ack = 1'b0;
    checks++;
    if ({bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o} !== {1'b0, 1'b1, 32'h8000_0100}) begin
      errors++; $display("FAIL drop_target: got valid=%b req=%b addr=%h want 0/1/80000100", bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_out_redirect;
    ready = 1'b0; man_ack = 1'b1; man_rdata = 32'h2222_2222;
    tick();
    man_ack = 1'b0;
    checks++;
    if ({bus.inst_valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'h8000_0100, 32'h2222_2222}) begin
      errors++; $display("FAIL outr_word: got valid=%b pc=%h inst=%h want 1/80000100/22222222", bus.inst_valid_o, bus.pc_o, bus.inst_o);
    end
    ready = 1'b1; redir_v = 1'b1; redir_pc = 32'h8000_0400;
    tick();
    redir_v = 1'b0;
    checks++;
    if ({bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o} !== {1'b0, 1'b1, 32'h8000_0400}) begin
      errors++; $display("FAIL outr_squash: got valid=%b req=%b addr=%h want 0/1/80000400", bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o);
    end
    man_ack = 1'b1; man_rdata = 32'h3333_3333;
    tick();
    man_ack = 1'b0;
    checks++;
    if ({bus.inst_valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'h8000_0400, 32'h3333_3333}) begin
      errors++; $display("FAIL outr_target: got valid=%b pc=%h inst=%h want 1/80000400/33333333", bus.inst_valid_o, bus.pc_o, bus.inst_o);
    end
    tick();
    checks++;
    if ({bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o} !== {1'b0, 1'b1, 32'h8000_0404}) begin
      errors++; $display("FAIL outr_next: got valid=%b req=%b addr=%h want 0/1/80000404", bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o);
    end
    man_ack = 1'b1; man_rdata = 32'h9999_9999; redir_v = 1'b1; redir_pc = 32'h8000_0800;
    tick();
    checks++;
    if ({bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o} !== {1'b0, 1'b1, 32'h8000_0800}) begin
      errors++; $display("FAIL ackredir: got valid=%b req=%b addr=%h want 0/1/80000800", bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_wrap;
    redir_pc = 32'hFFFF_FFFC;
    tick();
    redir_v = 1'b0; man_rdata = 32'h4444_4444;
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL wrap_req: got req=%b addr=%h want 1/fffffffc", bus.imem_req_o, bus.imem_addr_o);
    end
    tick();
    man_ack = 1'b0;
    checks++;
    if ({bus.inst_valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'hFFFF_FFFC, 32'h4444_4444}) begin
      errors++; $display("FAIL wrap_word: got valid=%b pc=%h inst=%h want 1/fffffffc/44444444", bus.inst_valid_o, bus.pc_o, bus.inst_o);
    end
    tick();
    checks++;
    if ({bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o} !== {1'b0, 1'b1, 32'h0000_0000}) begin
      errors++; $display("FAIL wrap_zero: got valid=%b req=%b addr=%h want 0/1/00000000", bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_misalign;
    man_ack = 1'b1; man_rdata = 32'h7777_7777; redir_v = 1'b1; redir_pc = 32'h8000_0102;
    tick();
    man_ack = 1'b0; redir_v = 1'b0;
`ifdef YSYX_22041211_IFU_MISALIGN_EN
    checks++;
    if ({bus.imem_req_o, bus.inst_valid_o, bus.fetch_fault_o, bus.pc_o, bus.inst_o} !== {1'b0, 1'b1, 1'b1, 32'h8000_0102, 32'd0}) begin
      errors++; $display("FAIL mis_fault: got req=%b valid=%b fault=%b pc=%h inst=%h want 0/1/1/80000102/0", bus.imem_req_o, bus.inst_valid_o, bus.fetch_fault_o, bus.pc_o, bus.inst_o);
    end
    for (int i = 0; i < 2; i++) begin
      man_ack = (i == 1);
      tick();
      checks++;
      if ({bus.imem_req_o, bus.inst_valid_o, bus.fetch_fault_o} !== 3'b000) begin
        errors++; $display("FAIL mis_halt%0d: got req=%b valid=%b fault=%b want 0/0/0", i, bus.imem_req_o, bus.inst_valid_o, bus.fetch_fault_o);
      end
    end
    man_ack = 1'b0; redir_v = 1'b1; redir_pc = RST_PC;
    tick();
    redir_v = 1'b0;
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, RST_PC}) begin
      errors++; $display("FAIL mis_resume: got req=%b addr=%h want 1/%h", bus.imem_req_o, bus.imem_addr_o, RST_PC);
    end
`else
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o} !== {1'b1, 32'h8000_0100, 1'b0}) begin
      errors++; $display("FAIL align_force: got req=%b addr=%h valid=%b want 1/80000100/0", bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o);
    end
`endif
  endtask

  task automatic test_reset_mid;
    man_ack = 1'b1; man_rdata = 32'h6666_6666;
    rst = 1'b1;
    #2;
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o} !== {1'b0, RST_PC, 1'b0}) begin
      errors++; $display("FAIL rstmid_async: got req=%b addr=%h valid=%b want 0/%h/0", bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o, RST_PC);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o} !== {1'b1, RST_PC, 1'b0}) begin
      errors++; $display("FAIL rstmid_restart: got req=%b addr=%h valid=%b want 1/%h/0", bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o, RST_PC);
    end
    man_rdata = 32'h5555_5555;
    tick();
    man_ack = 1'b0;
    checks++;
    if ({bus.inst_valid_o, bus.pc_o, bus.inst_o} !== {1'b1, RST_PC, 32'h5555_5555}) begin
      errors++; $display("FAIL rstmid_word: got valid=%b pc=%h inst=%h want 1/%h/55555555", bus.inst_valid_o, bus.pc_o, bus.inst_o, RST_PC);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait_ack();
    test_backpressure();
    test_drop();
    test_out_redirect();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
